// File: rtl/pi_txn_queue.sv
// pi_txn_queue: Pi register port that stages bus operations into a 4-deep FIFO for the bus engine.
// Optional STATUS readback is enabled by defining PI_TXNQ_STATUS_RB_EN.
`timescale 1ns/1ps
module pi_txn_queue (
  input  logic        PI_CLK,
  input  logic        PI_RST_n,
  input  logic [1:0]  PI_A,
  input  logic        PI_WR,
  input  logic        PI_RD,
  input  logic [15:0] PI_D_IN,
  output logic [15:0] PI_D_OUT,
  output logic        PI_D_OE,
  output logic        PI_TXN_IN_PROGRESS,
  output logic        op_valid,
  output logic [23:0] op_addr,
  output logic [15:0] op_wdata,
  output logic        op_rw,
  output logic        op_uds_n,
  output logic        op_lds_n,
  input  logic        op_ack,
  input  logic        op_done
);

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_ADDR_LO = 2'd1;
  localparam logic [1:0] REG_ADDR_HI = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] wdata;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
  } entry_t;

  logic [2:0]  wr_sync;
  logic [2:0]  rd_sync;
  logic        wr_evt;
  logic        rd_evt;
  logic [15:0] stage_addr;
  logic [15:0] stage_wdata;
  entry_t      mem [4];
  entry_t      head;
  entry_t      new_entry;
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic        inflight;
  logic        ovf;
  logic        err;
  logic        full;
  logic        pop;
  logic        push_req;
  logic        push;
  logic [15:0] status_word;

  // Bits [1:0] resynchronise each strobe; bit [2] keeps the previous synchronised sample for edge detection.
  always_ff @(posedge PI_CLK or negedge PI_RST_n) begin
    if (!PI_RST_n) begin
      wr_sync <= '0;
      rd_sync <= '0;
      wr_evt  <= 1'b0;
      rd_evt  <= 1'b0;
    end else begin
      wr_sync <= {wr_sync[1:0], PI_WR};
      rd_sync <= {rd_sync[1:0], PI_RD};
      wr_evt  <= wr_sync[1] & ~wr_sync[2];
      rd_evt  <= rd_sync[1] & ~rd_sync[2];
    end
  end

  always_comb begin
    full            = (count == 3'd4);
    pop             = op_ack && op_valid;
    push_req        = wr_evt && (PI_A == REG_ADDR_HI);
    push            = push_req && (!full || pop);
    new_entry.addr  = {PI_D_IN[7:0], stage_addr};
    new_entry.wdata = stage_wdata;
    new_entry.rw    = PI_D_IN[9];
    // Word access drives both strobes low; byte access selects the lane from address bit 0.
    new_entry.uds_n = PI_D_IN[8] & stage_addr[0];
    new_entry.lds_n = PI_D_IN[8] & ~stage_addr[0];
    status_word     = {count, inflight, ovf, err, 10'd0};
  end

  assign head     = mem[rd_ptr];
  assign op_valid = (count != 3'd0);
  assign op_addr  = head.addr;
  assign op_wdata = head.wdata;
  assign op_rw    = head.rw;
  assign op_uds_n = head.uds_n;
  assign op_lds_n = head.lds_n;

  always_ff @(posedge PI_CLK or negedge PI_RST_n) begin
    if (!PI_RST_n) begin
      stage_addr         <= '0;
      stage_wdata        <= '0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      inflight           <= 1'b0;
      ovf                <= 1'b0;
      err                <= 1'b0;
      PI_TXN_IN_PROGRESS <= 1'b0;
    end else begin
      if (wr_evt && (PI_A == REG_DATA)) stage_wdata <= PI_D_IN;
      if (wr_evt && (PI_A == REG_ADDR_LO)) stage_addr <= PI_D_IN;

      if (push_req && full && !pop) ovf <= 1'b1;
      else if (wr_evt && (PI_A == REG_STATUS) && PI_D_IN[0]) ovf <= 1'b0;

      // A second take while one cycle is still outstanding is flagged, but inflight stays a single flag.
      if (pop) begin
        if (inflight && !op_done) err <= 1'b1;
        inflight <= 1'b1;
      end else if (op_done) begin
        inflight <= 1'b0;
      end

      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push} - {2'b00, pop};

      PI_TXN_IN_PROGRESS <= (count != 3'd0) || inflight;
    end
  end

  always_ff @(posedge PI_CLK or negedge PI_RST_n) begin
    if (!PI_RST_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

`ifdef PI_TXNQ_STATUS_RB_EN
  always_ff @(posedge PI_CLK or negedge PI_RST_n) begin
    if (!PI_RST_n) PI_D_OUT <= '0;
    else if (rd_evt && (PI_A == REG_STATUS)) PI_D_OUT <= status_word;
  end

  assign PI_D_OE = PI_RST_n && (PI_A == REG_STATUS) && PI_RD;
`else
  // Status state is still maintained so the readback can be enabled without touching the queue logic.
  logic status_unused;
  assign status_unused = ^{rd_evt, status_word};
  assign PI_D_OUT      = '0;
  assign PI_D_OE       = 1'b0;
`endif

endmodule

// File: tb/tb_pi_txn_queue.sv
// tb_pi_txn_queue: randomized scoreboard bench for pi_txn_queue with a queue-based reference model.
// Define PI_TXNQ_STATUS_RB_EN on both files to exercise the STATUS readback.
`timescale 1ns/1ps
module tb_pi_txn_queue;

  logic        PI_CLK = 1'b0;
  logic        PI_RST_n = 1'b0;
  logic [1:0]  PI_A = '0;
  logic        PI_WR = 1'b0;
  logic        PI_RD = 1'b0;
  logic [15:0] PI_D_IN = '0;
  logic [15:0] PI_D_OUT;
  logic        PI_D_OE;
  logic        PI_TXN_IN_PROGRESS;
  logic        op_valid;
  logic [23:0] op_addr;
  logic [15:0] op_wdata;
  logic        op_rw;
  logic        op_uds_n;
  logic        op_lds_n;
  logic        op_ack = 1'b0;
  logic        op_done = 1'b0;

  pi_txn_queue dut (
    .PI_CLK(PI_CLK), .PI_RST_n(PI_RST_n), .PI_A(PI_A), .PI_WR(PI_WR), .PI_RD(PI_RD),
    .PI_D_IN(PI_D_IN), .PI_D_OUT(PI_D_OUT), .PI_D_OE(PI_D_OE),
    .PI_TXN_IN_PROGRESS(PI_TXN_IN_PROGRESS), .op_valid(op_valid), .op_addr(op_addr),
    .op_wdata(op_wdata), .op_rw(op_rw), .op_uds_n(op_uds_n), .op_lds_n(op_lds_n),
    .op_ack(op_ack), .op_done(op_done)
  );

  always #5 PI_CLK = ~PI_CLK;

  typedef struct {
    logic [23:0] addr;
    logic [15:0] wdata;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
  } exp_t;

  typedef struct {
    int          due;
    logic [1:0]  a;
    logic [15:0] d;
    bit          rd;
  } pend_t;

  exp_t  model_q[$];
  pend_t pend_q[$];
  logic [15:0] m_sa, m_sw, m_dout;
  bit    m_inflight, m_ovf, m_err, m_txn, m_wr_prev, m_rd_prev;
  int    edge_n = 0;
  int    tests = 0;
  int    fails = 0;
  bit    bus_rand_en = 1'b0;

  exp_t  mon_head, mon_new;
  pend_t mon_p;
  int    size_b;
  bit    infl_b, ovf_b, err_b, pop_m;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge PI_CLK);
    #1;
    if (bus_rand_en) begin
      op_ack  = ($urandom % 4) == 0;
      op_done = ($urandom % 3) == 0;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic [15:0] d, input bit rd);
    PI_A    = a;
    PI_D_IN = d;
    if (rd) PI_RD = 1'b1;
    else    PI_WR = 1'b1;
    repeat (4) tick();
    PI_WR = 1'b0;
    PI_RD = 1'b0;
    repeat (2) tick();
  endtask

  // Reference model and monitor: at each falling edge, check the present state and then advance the
  // model by the rising edge that follows, using the inputs that edge will see.
  always @(negedge PI_CLK) begin
    if (!PI_RST_n) begin
      model_q.delete();
      pend_q.delete();
      m_sa = '0; m_sw = '0; m_dout = '0;
      m_inflight = 0; m_ovf = 0; m_err = 0; m_txn = 0; m_wr_prev = 0; m_rd_prev = 0;
      checkOutput("rst_op_valid", {31'd0, op_valid}, 32'd0);
      checkOutput("rst_txn", {31'd0, PI_TXN_IN_PROGRESS}, 32'd0);
    end else begin
      checkOutput("op_valid", {31'd0, op_valid}, {31'd0, model_q.size() != 0});
      checkOutput("txn_in_progress", {31'd0, PI_TXN_IN_PROGRESS}, {31'd0, m_txn});
      checkOutput("count", {29'd0, dut.count}, model_q.size());
      checkOutput("inflight", {31'd0, dut.inflight}, {31'd0, m_inflight});
      checkOutput("ovf", {31'd0, dut.ovf}, {31'd0, m_ovf});
      checkOutput("err", {31'd0, dut.err}, {31'd0, m_err});
`ifdef PI_TXNQ_STATUS_RB_EN
      checkOutput("d_out", {16'd0, PI_D_OUT}, {16'd0, m_dout});
      checkOutput("d_oe", {31'd0, PI_D_OE}, {31'd0, (PI_A == 2'd3) && PI_RD});
`else
      checkOutput("d_out_off", {16'd0, PI_D_OUT}, 32'd0);
      checkOutput("d_oe_off", {31'd0, PI_D_OE}, 32'd0);
`endif
      size_b = model_q.size();
      infl_b = m_inflight;
      ovf_b  = m_ovf;
      err_b  = m_err;
      pop_m  = 1'b0;

      if (op_ack && op_valid && model_q.size() != 0) begin
        mon_head = model_q.pop_front();
        pop_m    = 1'b1;
        checkOutput("head_addr", {8'd0, op_addr}, {8'd0, mon_head.addr});
        checkOutput("head_wdata", {16'd0, op_wdata}, {16'd0, mon_head.wdata});
        checkOutput("head_rw", {31'd0, op_rw}, {31'd0, mon_head.rw});
        checkOutput("head_uds_n", {31'd0, op_uds_n}, {31'd0, mon_head.uds_n});
        checkOutput("head_lds_n", {31'd0, op_lds_n}, {31'd0, mon_head.lds_n});
      end

      if (pop_m) begin
        if (m_inflight && !op_done) m_err = 1'b1;
        m_inflight = 1'b1;
      end else if (op_done && m_inflight) begin
        m_inflight = 1'b0;
      end

      // A strobe first sampled high at edge k takes effect at edge k+3.
      if (PI_WR && !m_wr_prev) begin
        mon_p.due = edge_n + 3; mon_p.a = PI_A; mon_p.d = PI_D_IN; mon_p.rd = 1'b0;
        pend_q.push_back(mon_p);
      end
      if (PI_RD && !m_rd_prev) begin
        mon_p.due = edge_n + 3; mon_p.a = PI_A; mon_p.d = PI_D_IN; mon_p.rd = 1'b1;
        pend_q.push_back(mon_p);
      end
      m_wr_prev = PI_WR;
      m_rd_prev = PI_RD;

      while (pend_q.size() != 0 && pend_q[0].due == edge_n) begin
        mon_p = pend_q.pop_front();
        if (mon_p.rd) begin
          if (mon_p.a == 2'd3) m_dout = {3'(size_b), infl_b, ovf_b, err_b, 10'd0};
        end else begin
          case (mon_p.a)
            2'd0: m_sw = mon_p.d;
            2'd1: m_sa = mon_p.d;
            2'd2: begin
              mon_new.addr  = {mon_p.d[7:0], m_sa};
              mon_new.wdata = m_sw;
              mon_new.rw    = mon_p.d[9];
              mon_new.uds_n = mon_p.d[8] ? m_sa[0] : 1'b0;
              mon_new.lds_n = mon_p.d[8] ? !m_sa[0] : 1'b0;
              if (size_b < 4 || pop_m) model_q.push_back(mon_new);
              else m_ovf = 1'b1;
            end
            default: if (mon_p.d[0]) m_ovf = 1'b0;
          endcase
        end
      end
      m_txn = (size_b != 0) || infl_b;
    end
    edge_n++;
  end

  initial begin
    #1;
    checkOutput("rst_d_oe", {31'd0, PI_D_OE}, 32'd0);
    checkOutput("rst_d_out", {16'd0, PI_D_OUT}, 32'd0);
    checkOutput("rst_addr", {8'd0, op_addr}, 32'd0);
    repeat (3) tick();
    PI_RST_n = 1'b1;
    tick();

    // Single byte read operation and its enqueue latency.
    applyStimulus(2'd1, 16'h1235, 1'b0);
    applyStimulus(2'd0, 16'hBEEF, 1'b0);
    PI_A = 2'd2; PI_D_IN = 16'h0312; PI_WR = 1'b1;
    repeat (3) tick();
    checkOutput("latency_early", {31'd0, op_valid}, 32'd0);
    tick();
    checkOutput("latency_rise", {31'd0, op_valid}, 32'd1);
    checkOutput("op_addr_121235", {8'd0, op_addr}, 32'h121235);
    checkOutput("op_wdata_beef", {16'd0, op_wdata}, 32'hBEEF);
    checkOutput("op_rw_read", {31'd0, op_rw}, 32'd1);
    checkOutput("op_uds_n", {31'd0, op_uds_n}, 32'd1);
    checkOutput("op_lds_n", {31'd0, op_lds_n}, 32'd0);
    PI_WR = 1'b0;
    repeat (2) tick();

    // Take the operation, then complete it ten cycles later.
    op_ack = 1'b1; tick(); op_ack = 1'b0;
    repeat (10) begin
      tick();
      checkOutput("txn_hold", {31'd0, PI_TXN_IN_PROGRESS}, 32'd1);
    end
    op_done = 1'b1; tick(); op_done = 1'b0;
    checkOutput("txn_after_done", {31'd0, PI_TXN_IN_PROGRESS}, 32'd1);
    tick();
    checkOutput("txn_fall", {31'd0, PI_TXN_IN_PROGRESS}, 32'd0);

    // Overflow: five word-write pushes into a 4-deep queue.
    for (int i = 0; i < 5; i++) applyStimulus(2'd2, 16'h0020 + 16'(i), 1'b0);
    checkOutput("full_count", {29'd0, dut.count}, 32'd4);
    checkOutput("ovf_set", {31'd0, dut.ovf}, 32'd1);
    checkOutput("head_first", {8'd0, op_addr}, 32'h201235);
    applyStimulus(2'd3, 16'h0001, 1'b0);
    checkOutput("ovf_clear", {31'd0, dut.ovf}, 32'd0);

    // Push and take in the same cycle while full, then drain across the pointer wrap.
    PI_A = 2'd2; PI_D_IN = 16'h0030; PI_WR = 1'b1;
    repeat (3) tick();
    op_ack = 1'b1; tick(); op_ack = 1'b0;
    PI_WR = 1'b0;
    checkOutput("full_pushpop_count", {29'd0, dut.count}, 32'd4);
    checkOutput("full_pushpop_head", {8'd0, op_addr}, 32'h211235);
    checkOutput("full_pushpop_ovf", {31'd0, dut.ovf}, 32'd0);
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      op_ack = 1'b1; op_done = 1'b1; tick(); op_ack = 1'b0; op_done = 1'b0; tick();
    end
    checkOutput("drain_empty", {31'd0, op_valid}, 32'd0);
    op_done = 1'b1; tick(); op_done = 1'b0;

    // Reset with entries queued and one operation in flight.
    for (int i = 0; i < 3; i++) applyStimulus(2'd2, 16'h0140 + 16'(i), 1'b0);
    op_ack = 1'b1; tick(); op_ack = 1'b0;
    checkOutput("pre_rst_count", {29'd0, dut.count}, 32'd2);
    PI_RST_n = 1'b0;
    #1;
    checkOutput("rst_mid_valid", {31'd0, op_valid}, 32'd0);
    checkOutput("rst_mid_txn", {31'd0, PI_TXN_IN_PROGRESS}, 32'd0);
    checkOutput("rst_mid_addr", {8'd0, op_addr}, 32'd0);
    checkOutput("rst_mid_wdata", {16'd0, op_wdata}, 32'd0);
    checkOutput("rst_mid_inflight", {31'd0, dut.inflight}, 32'd0);
    repeat (2) tick();
    PI_RST_n = 1'b1;
    tick();
    op_done = 1'b1; tick(); op_done = 1'b0;
    checkOutput("done_after_rst", {31'd0, dut.inflight}, 32'd0);

`ifdef PI_TXNQ_STATUS_RB_EN
    applyStimulus(2'd2, 16'h0001, 1'b0);
    applyStimulus(2'd2, 16'h0002, 1'b0);
    applyStimulus(2'd3, 16'h0000, 1'b1);
    checkOutput("status_rb", {16'd0, PI_D_OUT}, 32'h4000);
`endif

    // Randomized register traffic against a randomly behaving bus engine.
    bus_rand_en = 1'b1;
    repeat (150) applyStimulus(2'($urandom % 4), 16'($urandom), ($urandom % 4) == 0);
    bus_rand_en = 1'b0;
    op_ack = 1'b0; op_done = 1'b0;
    tick();
    for (int i = 0; i < 8 && op_valid; i++) begin
      op_ack = 1'b1; op_done = 1'b1; tick(); op_ack = 1'b0; op_done = 1'b0; tick();
    end
    checkOutput("final_drain", {31'd0, op_valid}, 32'd0);
    op_done = 1'b1; tick(); op_done = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
